// File: rtl/ah_snoop_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ah_snoop_fifo_pkg
//  Purpose  : Shared defaults and width helpers for the snoopable FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
package ah_snoop_fifo_pkg;

    localparam int c_DEF_DWIDTH  = 140;
    localparam int c_DEF_DEPTH   = 78;
    localparam int c_DEF_KEY_LSB = 0;
    localparam int c_DEF_KEY_W   = 16;

    // Pointer width: indexes 0..depth-1, never narrower than one bit.
    function automatic int f_ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy width: must represent 0..depth inclusive.
    function automatic int f_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ah_snoop_fifo_match.sv
`default_nettype none
// ============================================================================
//  Module   : ah_snoop_fifo_match
//  Purpose  : Valid-gated key compare across all entries, OR-reduced to a
//             single hit flag. Purely combinational.
//  Revision : 1.0 - initial release
// ============================================================================
module ah_snoop_fifo_match #(
    parameter int DEPTH = 78,
    parameter int KEY_W = 16
) (
    input  logic [DEPTH-1:0]       valid,
    input  logic [DEPTH*KEY_W-1:0] keys,
    input  logic [KEY_W-1:0]       probe,
    output logic                   hit
);

    logic [DEPTH-1:0] w_eq;

    // One comparator per entry; an invalid slot never contributes a hit.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign w_eq[i] = valid[i] && (keys[i*KEY_W +: KEY_W] == probe);
    end

    assign hit = |w_eq;

endmodule
`default_nettype wire

// File: rtl/ah_snoop_fifo_gen2.sv
`default_nettype none
// ============================================================================
//  Module   : ah_snoop_fifo_gen2
//  Purpose  : First-word fall-through FIFO with a registered associative
//             snoop port that probes every resident entry's key field.
//  Revision : 1.0 - initial release
// ============================================================================
module ah_snoop_fifo_gen2
    import ah_snoop_fifo_pkg::*;
#(
    parameter int DWIDTH  = c_DEF_DWIDTH,
    parameter int DEPTH   = c_DEF_DEPTH,
    parameter int KEY_LSB = c_DEF_KEY_LSB,
    parameter int KEY_W   = c_DEF_KEY_W
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [DWIDTH-1:0]           wdata,
    input  logic                        wvalid,
    output logic                        wready,
    output logic [DWIDTH-1:0]           rdata,
    output logic                        rvalid,
    input  logic                        rready,
    input  logic [DWIDTH-1:0]           sdata,
    input  logic                        svalid,
    output logic                        smatch,
    output logic [f_cnt_w(DEPTH)-1:0]   count
);

    localparam int                PTR_W  = f_ptr_w(DEPTH);
    localparam int                CNT_W  = f_cnt_w(DEPTH);
    localparam logic [PTR_W-1:0]  c_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  c_FULL = CNT_W'(DEPTH);

    logic [DWIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH-1:0]       r_valid;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_smatch;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_hit;
    logic [DEPTH*KEY_W-1:0] w_keys;

    // Handshake flags come from the registered count alone.
    assign wready = (r_count != c_FULL);
    assign rvalid = (r_count != '0);
    assign w_push = wvalid && wready;
    assign w_pop  = rvalid && rready;

    assign rdata  = r_mem[r_rd_ptr];
    assign count  = r_count;
    assign smatch = r_smatch;

    // Entry storage carries no reset; the valid bits decide what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers wrap by compare so non-power-of-two depths stay gapless.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy tracks push/pop; a simultaneous pair leaves it unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Per-entry valid bits; push and pop slots coincide only when full or
    // empty, where one of the two is blocked, so the order here is moot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
            end
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
            end
        end
    end

    // Gather each entry's key field for the match array.
    for (genvar i = 0; i < DEPTH; i++) begin : g_keys
        assign w_keys[i*KEY_W +: KEY_W] = r_mem[i][KEY_LSB +: KEY_W];
    end

    ah_snoop_fifo_match #(
        .DEPTH (DEPTH),
        .KEY_W (KEY_W)
    ) u_match (
        .valid (r_valid),
        .keys  (w_keys),
        .probe (sdata[KEY_LSB +: KEY_W]),
        .hit   (w_hit)
    );

    // Snoop result sees pre-edge contents and drops to 0 without a request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_smatch <= 1'b0;
        end else begin
            r_smatch <= svalid && w_hit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ah_snoop_fifo_gen2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ah_snoop_fifo_gen2
//  Purpose  : Self-checking bench for ah_snoop_fifo_gen2 against a queue
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ah_snoop_fifo_gen2;

    localparam int DW = 140;
    localparam int DP = 78;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] sdata;
    logic          svalid;
    logic          smatch;
    logic [6:0]    count;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mdl[$];

    always #5 clk = ~clk;

    ah_snoop_fifo_gen2 dut (
        .clk    (clk),
        .rstn   (rstn),
        .wdata  (wdata),
        .wvalid (wvalid),
        .wready (wready),
        .rdata  (rdata),
        .rvalid (rvalid),
        .rready (rready),
        .sdata  (sdata),
        .svalid (svalid),
        .smatch (smatch),
        .count  (count)
    );

    function automatic logic [DW-1:0] mk(input logic [15:0] key);
        return {$urandom(), $urandom(), $urandom(), 28'($urandom()), key};
    endfunction

    function automatic logic key_present(input logic [15:0] key);
        foreach (mdl[i]) begin
            if (mdl[i][15:0] == key) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check pre-edge outputs against the model,
    // advance, update the model, check the registered snoop result.
    task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr,
                        input logic sv, input logic [15:0] sk);
        logic exp_sm, do_push, do_pop;
        wvalid = wv;
        wdata  = wd;
        rready = rr;
        svalid = sv;
        sdata  = mk(sk);
        chk("count",  {153'd0, count}, 160'(mdl.size()));
        chk("wready", {159'd0, wready}, 160'(mdl.size() < DP));
        chk("rvalid", {159'd0, rvalid}, 160'(mdl.size() > 0));
        if (mdl.size() > 0) chk("rdata", {20'd0, rdata}, {20'd0, mdl[0]});
        exp_sm  = sv && key_present(sk);
        do_push = wv && (mdl.size() < DP);
        do_pop  = rr && (mdl.size() > 0);
        @(posedge clk);
        #1;
        if (do_pop) void'(mdl.pop_front());
        if (do_push) mdl.push_back(wd);
        chk("smatch", {159'd0, smatch}, {159'd0, exp_sm});
        wvalid = 1'b0;
        rready = 1'b0;
        svalid = 1'b0;
    endtask

    initial begin
        int pushes, pops, cyc;
        logic wv, rr, sv;
        logic [15:0] sk;

        rstn = 1'b0; wvalid = 1'b0; rready = 1'b0; svalid = 1'b0;
        wdata = '0; sdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wready", {159'd0, wready}, 160'd1);
        chk("rst_rvalid", {159'd0, rvalid}, 160'd0);
        chk("rst_count",  {153'd0, count},  160'd0);
        chk("rst_smatch", {159'd0, smatch}, 160'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Fill with keys 0..77, then one extra push that must be dropped.
        for (int i = 0; i <= DP; i++) step(1'b1, mk(16'(i)), 1'b0, 1'b0, 16'd0);
        chk("full_wready", {159'd0, wready}, 160'd0);
        chk("full_count",  {153'd0, count},  160'd78);
        for (int i = 0; i < DP; i++) begin
            chk("drain_key", {144'd0, rdata[15:0]}, 160'(i));
            step(1'b0, '0, 1'b1, 1'b0, 16'd0);
        end
        chk("empty_rvalid", {159'd0, rvalid}, 160'd0);
        chk("empty_count",  {153'd0, count},  160'd0);

        // Refill, then push+pop together at full: pop wins, push dropped.
        for (int i = 0; i < DP; i++) step(1'b1, mk(16'h100 + 16'(i)), 1'b0, 1'b0, 16'd0);
        step(1'b1, mk(16'h999), 1'b1, 1'b1, 16'h999);
        chk("fullpp_count", {153'd0, count}, 160'd77);
        while (mdl.size() > 0) step(1'b0, '0, 1'b1, 1'b0, 16'd0);

        // Random interleave: 100 pushes / 100 pops, occupancy held to 1..5.
        pushes = 0; pops = 0; cyc = 0;
        while ((pushes < 100 || pops < 100) && cyc < 2000) begin
            wv = (pushes < 100) && (mdl.size() < 5) && ($urandom_range(0, 2) != 0);
            rr = (mdl.size() > 0) && (mdl.size() > 1 || pushes == 100) && ($urandom_range(0, 1) != 0);
            sv = $urandom_range(0, 1) != 0;
            sk = 16'h300 + 16'($urandom_range(0, 110));
            step(wv, mk(16'h300 + 16'(pushes)), rr, sv, sk);
            if (wv) pushes++;
            if (rr) pops++;
            cyc++;
        end
        chk("wrap_done", 160'(cyc < 2000), 160'd1);
        chk("wrap_count", {153'd0, count}, 160'd0);

        // Snoop hit / miss with keys 0x10 and 0x20 resident.
        step(1'b1, mk(16'h0010), 1'b0, 1'b0, 16'd0);
        step(1'b1, mk(16'h0020), 1'b0, 1'b0, 16'd0);
        step(1'b0, '0, 1'b0, 1'b1, 16'h0020);
        chk("hit_0020", {159'd0, smatch}, 160'd1);
        step(1'b0, '0, 1'b0, 1'b1, 16'h0030);
        chk("miss_0030", {159'd0, smatch}, 160'd0);
        step(1'b0, '0, 1'b0, 1'b1, 16'h0010);
        step(1'b0, '0, 1'b0, 1'b0, 16'h0010);
        chk("idle_smatch", {159'd0, smatch}, 160'd0);

        // Same-cycle pop still hits; same-cycle push does not, until next.
        step(1'b0, '0, 1'b1, 1'b1, 16'h0010);
        chk("pop_hit_0010", {159'd0, smatch}, 160'd1);
        step(1'b1, mk(16'h0040), 1'b0, 1'b1, 16'h0040);
        chk("push_miss_0040", {159'd0, smatch}, 160'd0);
        step(1'b0, '0, 1'b0, 1'b1, 16'h0040);
        chk("after_hit_0040", {159'd0, smatch}, 160'd1);
        while (mdl.size() > 0) step(1'b0, '0, 1'b1, 1'b0, 16'd0);

        // Reset mid-stream at count 40 with a snoop in flight.
        for (int i = 0; i < 40; i++) step(1'b1, mk(16'h200 + 16'(i)), 1'b0, 1'b0, 16'd0);
        step(1'b0, '0, 1'b0, 1'b1, 16'h0205);
        chk("pre_rst_hit", {159'd0, smatch}, 160'd1);
        svalid = 1'b1;
        sdata  = mk(16'h0210);
        #2;
        rstn = 1'b0;
        #1;
        mdl.delete();
        chk("mid_rst_rvalid", {159'd0, rvalid}, 160'd0);
        chk("mid_rst_wready", {159'd0, wready}, 160'd1);
        chk("mid_rst_count",  {153'd0, count},  160'd0);
        chk("mid_rst_smatch", {159'd0, smatch}, 160'd0);
        @(posedge clk);
        #1;
        svalid = 1'b0;
        rstn = 1'b1;
        step(1'b0, '0, 1'b0, 1'b1, 16'h0205);
        chk("post_rst_miss", {159'd0, smatch}, 160'd0);
        step(1'b1, mk(16'h0050), 1'b0, 1'b0, 16'd0);
        step(1'b0, '0, 1'b1, 1'b0, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
